flash_frame_loader: RTL and testbench

//   Loads one full frame from SPI flash into the HUB75 frame-buffer write port.

---
 rtl/flash_frame_loader.sv | 132 +++++++++++++
 tb/tb_flash_frame_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_frame_loader.sv
// Streams one frame from SPI flash into the HUB75 frame-buffer write port, one SPI read per row.
// Optional FFL_BYTE_SWAP_EN: first byte of each pixel lands in bits [7:0] instead of [15:8].
module flash_frame_loader #(
  parameter int N_ROWS   = 64,
  parameter int N_COLS   = 64,
  parameter int BITDEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [23:0]               frame_addr,
  input  logic                      frame_go,
  output logic                      busy,
  output logic [23:0]               sr_addr,
  output logic [15:0]               sr_len,
  output logic                      sr_go,
  input  logic                      sr_rdy,
  input  logic [7:0]                sr_data,
  input  logic                      sr_valid,
  output logic [$clog2(N_ROWS)-1:0] fbw_row_addr,
  output logic                      fbw_row_store,
  input  logic                      fbw_row_rdy,
  output logic                      fbw_row_swap,
  output logic [BITDEPTH-1:0]       fbw_data,
  output logic [$clog2(N_COLS)-1:0] fbw_col_addr,
  output logic                      fbw_wren,
  output logic                      frame_swap,
  input  logic                      frame_rdy
);

  localparam int RW = $clog2(N_ROWS);
  localparam int CW = $clog2(N_COLS);
  localparam int BW = CW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] FWAIT = 3'd4;

  logic [2:0]    state;
  logic [23:0]   base;
  logic [RW-1:0] row;
  logic [BW-1:0] byte_cnt;
  logic [7:0]    hold;
  logic [15:0]   pixel;

  assign sr_len = 16'(N_COLS * 2);

`ifdef FFL_BYTE_SWAP_EN
  assign pixel = {sr_data, hold};
`else
  assign pixel = {hold, sr_data};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      base          <= '0;
      row           <= '0;
      byte_cnt      <= '0;
      hold          <= '0;
      sr_addr       <= '0;
      sr_go         <= 1'b0;
      fbw_row_addr  <= '0;
      fbw_row_store <= 1'b0;
      fbw_row_swap  <= 1'b0;
      fbw_data      <= '0;
      fbw_col_addr  <= '0;
      fbw_wren      <= 1'b0;
      frame_swap    <= 1'b0;
    end else begin
      sr_go         <= 1'b0;
      fbw_wren      <= 1'b0;
      fbw_row_store <= 1'b0;
      fbw_row_swap  <= 1'b0;
      frame_swap    <= 1'b0;
      case (state)
        IDLE: begin
          // busy lingers through the frame_swap cycle and drops on the next one
          if (frame_swap) busy <= 1'b0;
          if (frame_go) begin
            base  <= frame_addr;
            row   <= '0;
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (sr_rdy && fbw_row_rdy) begin
            sr_go    <= 1'b1;
            sr_addr  <= base + 24'(row) * 24'(N_COLS * 2);
            byte_cnt <= '0;
            state    <= READ;
          end
        end
        READ: begin
          if (sr_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (!byte_cnt[0]) begin
              hold <= sr_data;
            end else begin
              fbw_wren     <= 1'b1;
              fbw_col_addr <= byte_cnt[BW-1:1];
              fbw_data     <= pixel;
            end
            if (byte_cnt == BW'(N_COLS * 2 - 1)) state <= STORE;
          end
        end
        STORE: begin
          fbw_row_store <= 1'b1;
          fbw_row_swap  <= 1'b1;
          fbw_row_addr  <= row;
          if (row == RW'(N_ROWS - 1)) begin
            state <= FWAIT;
          end else begin
            row   <= row + 1'b1;
            state <= WAIT;
          end
        end
        FWAIT: begin
          if (frame_rdy) begin
            frame_swap <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_frame_loader.sv
// Directed bench for flash_frame_loader: flash stream model, output recorder, linear checks.
module tb_flash_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] frame_addr = '0;
  logic        frame_go = 1'b0;
  logic        busy;
  logic [23:0] sr_addr;
  logic [15:0] sr_len;
  logic        sr_go;
  logic        sr_rdy = 1'b1;
  logic [7:0]  sr_data = '0;
  logic        sr_valid = 1'b0;
  logic [5:0]  fbw_row_addr;
  logic        fbw_row_store;
  logic        fbw_row_rdy = 1'b1;
  logic        fbw_row_swap;
  logic [15:0] fbw_data;
  logic [5:0]  fbw_col_addr;
  logic        fbw_wren;
  logic        frame_swap;
  logic        frame_rdy = 1'b0;

`ifdef FFL_BYTE_SWAP_EN
  localparam logic [15:0] EXP_C0  = 16'h0100;
  localparam logic [15:0] EXP_C63 = 16'h7F7E;
`else
  localparam logic [15:0] EXP_C0  = 16'h0001;
  localparam logic [15:0] EXP_C63 = 16'h7E7F;
`endif

  flash_frame_loader #(.N_ROWS(64), .N_COLS(64), .BITDEPTH(16)) dut (
    .clk(clk), .rst(rst), .frame_addr(frame_addr), .frame_go(frame_go), .busy(busy),
    .sr_addr(sr_addr), .sr_len(sr_len), .sr_go(sr_go), .sr_rdy(sr_rdy),
    .sr_data(sr_data), .sr_valid(sr_valid), .fbw_row_addr(fbw_row_addr),
    .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy), .fbw_row_swap(fbw_row_swap),
    .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
    .frame_swap(frame_swap), .frame_rdy(frame_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash model: after each sr_go, returns bytes 0x00..0x7F, one per cycle.
  int         fl_cnt = 0;
  logic [7:0] fl_byte = '0;
  always @(negedge clk) begin
    sr_valid = 1'b0;
    if (fl_cnt != 0) begin
      sr_valid = 1'b1;
      sr_data  = fl_byte;
      fl_byte  = fl_byte + 8'd1;
      fl_cnt   = fl_cnt - 1;
      if (fl_cnt == 0) sr_rdy = 1'b1;
    end else if (sr_go) begin
      sr_rdy  = 1'b0;
      fl_cnt  = 128;
      fl_byte = '0;
    end
  end

  function automatic logic [15:0] exp_pix(input logic [7:0] b);
`ifdef FFL_BYTE_SWAP_EN
    return {b, b - 8'd1};
`else
    return {b - 8'd1, b};
`endif
  endfunction

  // Recorder: samples 1 time unit after each posedge.
  int          wren_cnt = 0, store_cnt = 0, fswap_cnt = 0, bad_pix = 0, bad_row = 0;
  logic [5:0]  exp_row = '0;
  logic [15:0] col_data [64];
  logic [23:0] go_addr [$];
  always begin
    @(posedge clk);
    #1;
    if (fbw_wren) begin
      wren_cnt++;
      if (!(sr_valid && sr_data[0]) || fbw_col_addr !== sr_data[6:1] ||
          fbw_data !== exp_pix(sr_data)) bad_pix++;
      col_data[fbw_col_addr] = fbw_data;
    end
    if (fbw_row_store) begin
      if (!fbw_row_swap || fbw_row_addr !== exp_row) bad_row++;
      exp_row = exp_row + 6'd1;
      store_cnt++;
    end else if (fbw_row_swap) begin
      bad_row++;
    end
    if (frame_swap) fswap_cnt++;
    if (sr_go) go_addr.push_back(sr_addr);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_sr_go", {31'b0, sr_go}, 0);
    chk("rst_wren", {31'b0, fbw_wren}, 0);
    chk("rst_store", {30'b0, fbw_row_store, fbw_row_swap}, 0);
    chk("rst_fswap", {31'b0, frame_swap}, 0);
    chk("rst_sr_addr", {8'b0, sr_addr}, 0);
    chk("rst_fbw", {4'b0, fbw_row_addr, fbw_col_addr, fbw_data}, 0);
    chk("sr_len", {16'b0, sr_len}, 32'd128);
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: row buffer stall at row 3, ignored frame_go at row 10, frame_rdy held low.
    frame_addr = 24'h040000;
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    frame_addr = 24'h0;
    chk("busy_after_go", {31'b0, busy}, 1);

    for (int t = 0; t < 2000 && !(fbw_row_store && fbw_row_addr == 6'd3); t++) @(negedge clk);
    chk("row3_store_seen", {31'b0, fbw_row_store}, 1);
    fbw_row_rdy = 1'b0;
    repeat (50) @(negedge clk);
    chk("stall_no_go", go_addr.size(), 4);
    chk("stall_busy", {31'b0, busy}, 1);
    fbw_row_rdy = 1'b1;
    for (int t = 0; t < 10 && go_addr.size() < 5; t++) @(negedge clk);
    chk("row4_addr", {8'b0, go_addr[4]}, 32'h040200);

    for (int t = 0; t < 3000 && go_addr.size() < 11; t++) @(negedge clk);
    frame_addr = 24'h123456;
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;

    for (int t = 0; t < 20000 && store_cnt < 64; t++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("fwait_busy", {31'b0, busy}, 1);
    chk("fwait_no_swap", fswap_cnt, 0);
    frame_rdy = 1'b1;
    @(negedge clk);
    chk("frame_swap_pulse", {31'b0, frame_swap}, 1);
    chk("busy_during_swap", {31'b0, busy}, 1);
    @(negedge clk);
    chk("frame_swap_1cyc", {31'b0, frame_swap}, 0);
    chk("busy_drop", {31'b0, busy}, 0);
    chk("f1_wren_cnt", wren_cnt, 4096);
    chk("f1_store_cnt", store_cnt, 64);
    chk("f1_go_cnt", go_addr.size(), 64);
    chk("f1_row1_addr", {8'b0, go_addr[1]}, 32'h040080);
    chk("f1_row11_addr", {8'b0, go_addr[11]}, 32'h040580);
    chk("f1_row63_addr", {8'b0, go_addr[63]}, 32'h041F80);
    chk("col0_data", {16'b0, col_data[0]}, {16'b0, EXP_C0});
    chk("col63_data", {16'b0, col_data[63]}, {16'b0, EXP_C63});
    chk("f1_pixels", bad_pix, 0);
    chk("f1_rows", bad_row, 0);

    // Frame 2: address wrap, then reset in the middle of row 5.
    go_addr.delete();
    store_cnt = 0;
    frame_addr = 24'hFFFF80;
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    for (int t = 0; t < 1000 && go_addr.size() < 2; t++) @(negedge clk);
    chk("wrap_row0", {8'b0, go_addr[0]}, 32'hFFFF80);
    chk("wrap_row1", {8'b0, go_addr[1]}, 32'h000000);
    for (int t = 0; t < 2000 && go_addr.size() < 6; t++) @(negedge clk);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_strobes", {27'b0, sr_go, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap}, 0);
    rst = 1'b0;
    n = wren_cnt;
    for (int t = 0; t < 200 && fl_cnt != 0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("drain_no_wren", wren_cnt, n);
    chk("drain_idle", {31'b0, busy}, 0);
    chk("f2_stores", store_cnt, 5);

    // Frame 3: restart from row 0 after the abort, frame_rdy already high.
    exp_row = '0;
    go_addr.delete();
    store_cnt = 0;
    frame_addr = 24'h010000;
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    for (int t = 0; t < 20000 && fswap_cnt < 2; t++) @(negedge clk);
    chk("f3_swap", fswap_cnt, 2);
    chk("f3_row0_addr", {8'b0, go_addr[0]}, 32'h010000);
    chk("f3_row63_addr", {8'b0, go_addr[63]}, 32'h011F80);
    chk("f3_store_cnt", store_cnt, 64);
    chk("f3_pixels", bad_pix, 0);
    chk("f3_rows", bad_row, 0);
    @(negedge clk);
    chk("f3_busy_drop", {31'b0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
